// File: rtl/uart_tx_sequencer.sv
// Byte FIFO feeding the UART transmit register via cs/rd/wr strobes, one byte per transfer.
// Define UART_SEQ_STATUS_POLL_EN to pace on the UART Tx-ready bit instead of a fixed gap.
module uart_tx_sequencer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int CTRL_ADDR    = 0,
  parameter int TX_ADDR      = 2,
  parameter int TX_READY_BIT = 0,
  parameter int GAP_CYCLES   = 4200
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  input  logic [7:0]               push_data_i,
  output logic                     push_ready_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     busy_o,
  output logic                     sent_pulse_o,
  output logic                     uart_cs_o,
  output logic                     uart_rd_o,
  output logic                     uart_wr_o,
  output logic [ADDR_WIDTH-1:0]    uart_addr_o,
  output logic [7:0]               uart_in_data_o,
  input  logic [7:0]               uart_out_data_i
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_POLL_SMP,
    ST_POLL_WAIT,
    ST_LOAD,
    ST_WRITE,
    ST_RELEASE,
    ST_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [PW:0]             count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    push_ok;
  logic                    pop;

`ifndef UART_SEQ_STATUS_POLL_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : GW'(0);
  logic [GW-1:0] gap_q, gap_d;
  logic          unused_poll_cfg;
  assign unused_poll_cfg = ^{uart_out_data_i, 32'(CTRL_ADDR), 32'(TX_READY_BIT)};
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^32'(GAP_CYCLES);
`endif

  assign push_ready_o = (count_q != (PW+1)'(DEPTH));
  assign push_ok      = push_valid_i && push_ready_o;
  assign pop          = (state_q == ST_WRITE);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifndef UART_SEQ_STATUS_POLL_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
`ifdef UART_SEQ_STATUS_POLL_EN
          state_d = ST_POLL_RD;
          addr_d  = ADDR_WIDTH'(CTRL_ADDR);
`else
          state_d = ST_LOAD;
          addr_d  = ADDR_WIDTH'(TX_ADDR);
          data_d  = mem_q[rptr_q];
`endif
        end
      end
`ifdef UART_SEQ_STATUS_POLL_EN
      ST_POLL_RD:   state_d = ST_POLL_SMP;
      ST_POLL_SMP: begin
        if (uart_out_data_i[TX_READY_BIT]) begin
          state_d = ST_LOAD;
          addr_d  = ADDR_WIDTH'(TX_ADDR);
          data_d  = mem_q[rptr_q];
        end else begin
          state_d = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: state_d = ST_POLL_RD;
`endif
      ST_LOAD:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RELEASE;
      ST_RELEASE: begin
`ifdef UART_SEQ_STATUS_POLL_EN
        state_d = ST_IDLE;
`else
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
`endif
      end
`ifndef UART_SEQ_STATUS_POLL_EN
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage array carries no reset; pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifndef UART_SEQ_STATUS_POLL_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
`ifndef UART_SEQ_STATUS_POLL_EN
      gap_q   <= gap_d;
`endif
    end
  end

  // Strobes decode the state register alone so they carry no combinational input paths.
  assign uart_cs_o      = !(state_q == ST_POLL_RD || state_q == ST_POLL_SMP ||
                            state_q == ST_LOAD    || state_q == ST_WRITE);
  assign uart_rd_o      = !(state_q == ST_POLL_RD || state_q == ST_POLL_SMP);
  assign uart_wr_o      = !(state_q == ST_WRITE);
  assign sent_pulse_o   = (state_q == ST_RELEASE);
  assign busy_o         = (count_q != '0) || (state_q != ST_IDLE);
  assign fifo_count_o   = count_q;
  assign uart_addr_o    = addr_q;
  assign uart_in_data_o = data_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: directed timing tasks plus a queue-based byte scoreboard.
module tb_uart_tx_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_valid = 1'b0;
  logic [7:0]    push_data = 8'h00;
  logic          push_ready;
  logic [2:0]    fifo_count;
  logic          busy, sent_pulse, uart_cs, uart_rd, uart_wr;
  logic [AW-1:0] uart_addr;
  logic [7:0]    uart_in_data;
  logic [7:0]    uart_out_data;

  int checks = 0;
  int errors = 0;

  uart_tx_sequencer #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CTRL_ADDR(0), .TX_ADDR(2),
    .TX_READY_BIT(0), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .push_valid_i(push_valid), .push_data_i(push_data),
    .push_ready_o(push_ready), .fifo_count_o(fifo_count), .busy_o(busy),
    .sent_pulse_o(sent_pulse), .uart_cs_o(uart_cs), .uart_rd_o(uart_rd),
    .uart_wr_o(uart_wr), .uart_addr_o(uart_addr), .uart_in_data_o(uart_in_data),
    .uart_out_data_i(uart_out_data)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy from accepted pushes and observed writes, bytes in arrival order.
  int         m_count;
  logic       m_acc, m_pop;
  logic [7:0] exp_q[$];
  logic [7:0] wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int         sent_cnt;
  int         rd_low_cyc;

  assign m_acc = push_valid && (m_count != DEPTH);
  assign m_pop = (uart_wr === 1'b0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count    <= 0;
      sent_cnt   <= 0;
      rd_low_cyc <= 0;
    end else begin
      m_count <= m_count + int'(m_acc) - int'(m_pop);
      if (sent_pulse === 1'b1) sent_cnt <= sent_cnt + 1;
      if (uart_rd === 1'b0) rd_low_cyc <= rd_low_cyc + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (m_acc) exp_q.push_back(push_data);
      if (m_pop) begin
        wr_data_q.push_back(uart_in_data);
        wr_addr_q.push_back(uart_addr);
      end
    end
  end

  // UART status model: Tx-ready reads 0 for the first three polls (two rd-low cycles each).
  assign uart_out_data = (rd_low_cyc >= 6) ? 8'h01 : 8'h00;

  task automatic apply_reset();
    @(negedge clk);
    push_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    wr_data_q.delete();
    wr_addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({uart_cs, uart_rd, uart_wr, push_ready, busy, sent_pulse, fifo_count} !== 9'b111100_000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got cs/rd/wr/rdy/busy/sent/cnt=%b want 111100_000", c,
                 {uart_cs, uart_rd, uart_wr, push_ready, busy, sent_pulse, fifo_count});
      end
    end
    checks++;
    if (sent_cnt !== 0) begin errors++; $display("FAIL reset_sent: got %0d want 0", sent_cnt); end
  endtask

  task automatic test_single_write();
    logic exp_wr, exp_cs, exp_sent, exp_busy;
    apply_reset();
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 8'h4F;
    @(negedge clk);
    push_valid = 1'b0;
    // k counts cycles after the accepting edge: Idle, Load, Write, Release, Gap x4, Idle.
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      exp_wr   = (k != 2);
      exp_cs   = !(k == 1 || k == 2);
      exp_sent = (k == 3);
      exp_busy = (k <= 7);
      checks++;
      if ({uart_cs, uart_rd, uart_wr, sent_pulse, busy} !== {exp_cs, 1'b1, exp_wr, exp_sent, exp_busy}) begin
        errors++;
        $display("FAIL single_timing k=%0d: got cs/rd/wr/sent/busy=%b want %b", k,
                 {uart_cs, uart_rd, uart_wr, sent_pulse, busy}, {exp_cs, 1'b1, exp_wr, exp_sent, exp_busy});
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({uart_addr, uart_in_data} !== {3'd2, 8'h4F}) begin
          errors++;
          $display("FAIL single_bus k=%0d: got addr=%0d data=%h want addr=2 data=4f", k, uart_addr, uart_in_data);
        end
      end
    end
    checks++;
    if (sent_cnt !== 1) begin errors++; $display("FAIL single_sent_count: got %0d want 1", sent_cnt); end
  endtask

  task automatic test_fill_drain();
    int   i = 0;
    int   cyc = 0;
    logic saw_full = 1'b0;
    logic will;
    apply_reset();
    while (i < 6 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (fifo_count !== 3'(m_count) || push_ready !== (m_count != DEPTH)) begin
        errors++;
        $display("FAIL fill_count cyc %0d: got cnt=%0d rdy=%b want cnt=%0d rdy=%b", cyc,
                 fifo_count, push_ready, m_count, (m_count != DEPTH));
      end
      if (m_count == DEPTH) saw_full = 1'b1;
      push_valid = 1'b1;
      push_data  = 8'(8'h41 + i);
      will = (m_count != DEPTH);
      @(posedge clk);
      if (will) i++;
    end
    @(negedge clk);
    push_valid = 1'b0;
    checks++;
    if (i != 6 || !saw_full) begin
      errors++;
      $display("FAIL fill_progress: got pushed=%0d full_seen=%b want 6 1", i, saw_full);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    checks++;
    if (busy !== 1'b0 || wr_data_q.size() != 6) begin
      errors++;
      $display("FAIL fill_drain: got busy=%b writes=%0d want 0 6", busy, wr_data_q.size());
    end
    for (int j = 0; j < 6 && j < wr_data_q.size(); j++) begin
      checks++;
      if (wr_data_q[j] !== 8'(8'h41 + j) || wr_addr_q[j] !== 3'd2) begin
        errors++;
        $display("FAIL fill_order %0d: got %h@%0d want %h@2", j, wr_data_q[j], wr_addr_q[j], 8'(8'h41 + j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    apply_reset();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'(m_count) || push_ready !== (m_count != DEPTH)) begin
        errors++;
        $display("FAIL b2b_count cyc %0d: got cnt=%0d rdy=%b want cnt=%0d", c, fifo_count, push_ready, m_count);
      end
      push_valid = (c < 50) ? 1'b1 : ($urandom_range(0, 2) == 0);
      push_data  = 8'($urandom);
    end
    @(negedge clk);
    push_valid = 1'b0;
    while (busy === 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    checks++;
    if (busy !== 1'b0 || wr_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_drain: got busy=%b writes=%0d want 0 %0d", busy, wr_data_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < wr_data_q.size(); j++) begin
      checks++;
      if (wr_data_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL b2b_byte %0d: got %h want %h", j, wr_data_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc = 0;
    apply_reset();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      push_valid = 1'b1;
      push_data  = 8'($urandom);
    end
    @(negedge clk);
    push_valid = 1'b0;
    while (uart_wr !== 1'b0 && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (uart_wr !== 1'b0 || fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL midwr_setup: got wr=%b cnt=%0d want 0 3", uart_wr, fifo_count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({uart_cs, uart_rd, uart_wr, push_ready, busy, fifo_count} !== 8'b1111_0_000) begin
      errors++;
      $display("FAIL midwr_async: got cs/rd/wr/rdy/busy/cnt=%b want 11110000",
               {uart_cs, uart_rd, uart_wr, push_ready, busy, fifo_count});
    end
    exp_q.delete();
    wr_data_q.delete();
    wr_addr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (wr_data_q.size() != 0 || sent_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midwr_after: got writes=%0d sent=%0d busy=%b want 0 0 0", wr_data_q.size(), sent_cnt, busy);
    end
  endtask

`ifdef UART_SEQ_STATUS_POLL_EN
  task automatic test_poll();
    int cyc = 0;
    apply_reset();
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = 8'h5A;
    @(negedge clk);
    push_valid = 1'b0;
    while (uart_wr !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (uart_wr !== 1'b0 || rd_low_cyc != 8 || wr_data_q.size() != 0) begin
      errors++;
      $display("FAIL poll_iter: got wr=%b rd_cycles=%0d early_writes=%0d want 0 8 0", uart_wr, rd_low_cyc, wr_data_q.size());
    end
    checks++;
    if ({uart_addr, uart_in_data} !== {3'd2, 8'h5A}) begin
      errors++;
      $display("FAIL poll_bus: got addr=%0d data=%h want 2 5a", uart_addr, uart_in_data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_data_q.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL poll_done: got writes=%0d busy=%b want 1 0", wr_data_q.size(), busy);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_SEQ_STATUS_POLL_EN
    test_poll();
`else
    test_single_write();
`endif
    test_fill_drain();
    test_back_to_back();
    test_reset_mid_write();
`ifndef UART_SEQ_STATUS_POLL_EN
    checks++;
    if (rd_low_cyc != 0) begin errors++; $display("FAIL rd_idle: got %0d rd-low cycles want 0", rd_low_cyc); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

- Buffered bus master that feeds the UART_Component transmit path from a parametrised byte FIFO.
- Replaces hand-written single-byte write sequences in top-level state machines: producers push bytes with a valid/ready handshake, and the sequencer performs the chip-select/write strobes on the UART register bus, one byte per transfer.
- Before each write it paces transmission, either by polling the UART control register or by a fixed inter-byte gap.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 3: UART register address width.
- CTRL_ADDR, 0: control/status register address.
- TX_ADDR, 2: Tx buffer address.
- TX_READY_BIT, 0: bit of control register; 1 = Tx buffer can accept a byte.
- GAP_CYCLES, 4200: inter-byte wait in clocks (used only without the macro).
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- push_valid  in  1  producer offers push_data.
- push_data  in  8  byte to queue.
- push_ready  out  1  FIFO not full; push occurs when valid & ready at clock edge.
- fifo_count  out  $clog2(DEPTH)+1  bytes queued, 0..DEPTH.
- busy  out  1  FIFO non-empty or state ≠ Idle.
- sent_pulse  out  1  one-cycle pulse on each completed UART write.
- uart_cs  out  1  chip select, active low.
- uart_rd  out  1  read strobe, active low.
- uart_wr  out  1  write strobe, active low.
- uart_addr  out  ADDR_WIDTH  register address, registered.
- uart_in_data  out  8  byte to UART, registered.
- uart_out_data  in  8  UART read data.

## Operation
- FIFO: circular, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; count held separately.
- push_ready = (count != DEPTH), taken from the registered count. A push at full is ignored even if a pop occurs in the same cycle.
- Simultaneous push and pop leaves the count unchanged.
- FSM states:
  - Idle: all strobes high. If count > 0, go to PollRead (macro) or Load.
  - PollRead: cs=0, rd=0, addr=CTRL_ADDR. Go to PollSample.
  - PollSample: cs=0, rd=0. Sample uart_out_data[TX_READY_BIT]; 1 → Load, 0 → PollWait.
  - PollWait: strobes high for one cycle. Go to PollRead.
  - Load: cs=0. uart_addr ← TX_ADDR and uart_in_data ← FIFO head, both registered on entry. Go to Write.
  - Write: cs=0, wr=0. Pop the FIFO at the end of this cycle. Go to Release.
  - Release: strobes high, sent_pulse=1. Go to Gap (no macro) or Idle (macro).
  - Gap: a down-counter loaded with GAP_CYCLES-1 counts to 0, then go to Idle. GAP_CYCLES=0 or 1 gives a single Gap cycle.
- Strobes are decoded from the state register only; they never depend on inputs combinationally.
- Pushes are accepted in every state.

## Timing
- Reset values (asynchronous, immediate):
  - state=Idle, FIFO empty, fifo_count=0, push_ready=1, busy=0.
  - uart_cs/uart_rd/uart_wr=1.
  - uart_addr=0, uart_in_data=0, sent_pulse=0, gap counter=0.
- Reset mid-transfer aborts the current transfer, discards queued bytes, and raises all strobes in the same instant.
- Push-to-wr latency from empty/Idle: the push edge, then Idle, Load, Write. uart_wr falls 3 clocks after the push edge (no macro). With the macro and the ready bit already set, it falls 5 clocks after.
- uart_addr/uart_in_data are stable from Load through Release.
- Back-to-back throughput:
  - Without macro: 4 + max(GAP_CYCLES,1) clocks per byte.
  - With macro: 6 clocks minimum per byte.
- fifo_count updates the clock after a push or pop edge.

## Configuration
- UART_SEQ_STATUS_POLL_EN defined: flow-controlled by the UART. PollRead/PollSample/PollWait are used and Gap is never entered. GAP_CYCLES is unused.
- Not defined: blind pacing. Poll states and read logic are compiled out, and uart_rd is held at 1. Every write is followed by GAP_CYCLES of Gap.

## Test plan
- Reset then idle 20 clocks: all strobes 1, push_ready=1, fifo_count=0, busy=0, no sent_pulse.
- No macro, GAP_CYCLES=4: push 0x4F.
  - uart_wr low for exactly 1 clock, 3 clocks after the push, with uart_addr=2 and uart_in_data=0x4F.
  - One sent_pulse; Idle again 5 clocks after Release.
- DEPTH=4: push 6 bytes 0x41..0x46 with push_valid held.
  - push_ready drops at count=4.
  - All 6 bytes are written in order, once each, as the FIFO drains and re-accepts.
  - Pointer wrap is exercised.
- Macro: model returns ready bit 0 for 3 polls, then 1.
  - Exactly 3 PollRead/PollSample/PollWait iterations, with no uart_wr low before ready.
  - Then a single write of the head byte.
- Assert reset during Write with 3 bytes queued: strobes go high immediately, fifo_count=0, and no further writes after release.
- Push every cycle while draining at full: simultaneous push/pop keeps the count constant; no byte lost or duplicated (scoreboard compare).
